// File: rtl/input_debouncer.sv
// input_debouncer: resynchronizes an asynchronous, bouncy level to clk and
// only lets it through once it has held its new value for STABLE_CYCLES
// consecutive synchronized samples. Produces a registered clean level plus
// one-cycle rise/fall strobes and a busy flag while a change is qualifying.
module input_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic in_raw,
  input  logic enable,
  output logic out_level,
  output logic rise,
  output logic fall,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  // Last count value before the level is allowed to flip; the counter never exceeds it.
  localparam logic [CNT_WIDTH-1:0] COUNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] COUNT_ONE  = CNT_WIDTH'(1);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync;

  state_t                 state;
  state_t                 state_next;
  logic [CNT_WIDTH-1:0]   count;
  logic [CNT_WIDTH-1:0]   count_next;
  logic                   level_next;
  logic                   rise_next;
  logic                   fall_next;
  logic                   busy_next;

  // Synchronizer chain: the only logic that ever looks at in_raw; runs regardless of enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], in_raw};
    end
  end

  assign sync = sync_chain[SYNC_STAGES-1];

  // State, counter and all outputs are registered together so the strobes line up with the level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE_LOW;
      count     <= '0;
      out_level <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      out_level <= level_next;
      rise      <= rise_next;
      fall      <= fall_next;
      busy      <= busy_next;
    end
  end

  // Next-state logic: count consecutive enabled samples that disagree with the current level.
  always_comb begin
    state_next = state;
    count_next = count;
    level_next = out_level;
    rise_next  = 1'b0;
    fall_next  = 1'b0;

    case (state)
      IDLE_LOW: begin
        count_next = '0;
        if (enable && sync) begin
          if (STABLE_CYCLES == 1) begin
            state_next = IDLE_HIGH;
            level_next = 1'b1;
            rise_next  = 1'b1;
          end else begin
            state_next = WAIT_HIGH;
            count_next = COUNT_ONE;
          end
        end
      end

      WAIT_HIGH: begin
        if (!enable || !sync) begin
          state_next = IDLE_LOW;
          count_next = '0;
        end else if (count == COUNT_LAST) begin
          state_next = IDLE_HIGH;
          count_next = '0;
          level_next = 1'b1;
          rise_next  = 1'b1;
        end else begin
          count_next = count + COUNT_ONE;
        end
      end

      IDLE_HIGH: begin
        count_next = '0;
        if (enable && !sync) begin
          if (STABLE_CYCLES == 1) begin
            state_next = IDLE_LOW;
            level_next = 1'b0;
            fall_next  = 1'b1;
          end else begin
            state_next = WAIT_LOW;
            count_next = COUNT_ONE;
          end
        end
      end

      WAIT_LOW: begin
        if (!enable || sync) begin
          state_next = IDLE_HIGH;
          count_next = '0;
        end else if (count == COUNT_LAST) begin
          state_next = IDLE_LOW;
          count_next = '0;
          level_next = 1'b0;
          fall_next  = 1'b1;
        end else begin
          count_next = count + COUNT_ONE;
        end
      end

      default: begin
        state_next = IDLE_LOW;
        count_next = '0;
        level_next = 1'b0;
      end
    endcase

    busy_next = (state_next == WAIT_HIGH) || (state_next == WAIT_LOW);
  end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Conditioning stage that sits directly upstream of the design's D flip-flop data inputs.
- Takes an asynchronous, bouncy level, for example a board switch or button, that would otherwise feed a DFF `d` pin raw.
- Resynchronizes that level to `clk` through a flip-flop chain, then applies a counter-based stability filter.
- Outputs a clean registered level plus single-cycle rise and fall strobes that downstream registers consume.

Parameters:
- SYNC_STAGES, 2: number of synchronizer flip-flops. Legal range is 2 or more.
- STABLE_CYCLES, 4: number of consecutive synchronized samples that must differ from `out_level` before it toggles. Legal range is 1 or more.
- CNT_WIDTH, 8: width of the stability counter. Must satisfy 2^CNT_WIDTH > STABLE_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous reset, active-high.
- in_raw  input  1  asynchronous, possibly bouncing input level.
- enable  input  1  filter enable. When low, outputs freeze.
- out_level  output  1  debounced, registered level.
- rise  output  1  one-cycle pulse when `out_level` goes 0->1.
- fall  output  1  one-cycle pulse when `out_level` goes 1->0.
- busy  output  1  high while a candidate transition is being qualified.

Behaviour:
- Reset (async, active-high):
  - All synchronizer stages = 0.
  - Counter = 0.
  - FSM = IDLE_LOW.
  - out_level = 0, rise = 0, fall = 0, busy = 0.
  - Reset asserted mid-qualification discards the pending count immediately and produces no pulse.
- Synchronizer:
  - Shift chain clocked every cycle regardless of `enable`.
  - `sync` = last stage.
  - No logic other than the chain may observe `in_raw`.
- FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
- IDLE_LOW:
  - If enable && sync=1: go to WAIT_HIGH, counter=1.
  - If STABLE_CYCLES=1, go straight to IDLE_HIGH with out_level=1 and rise=1 on that edge.
- WAIT_HIGH (busy=1):
  - If !enable or sync=0: go to IDLE_LOW, counter=0, no pulse.
  - Else if counter==STABLE_CYCLES-1: go to IDLE_HIGH, out_level<=1, rise<=1, counter=0.
  - Else counter++.
- IDLE_HIGH and WAIT_LOW: mirror images with sync=0, out_level<=0, fall<=1.
- Outputs:
  - All outputs are registered.
  - rise and fall are high for exactly one cycle, on the cycle out_level first shows its new value.
  - rise and fall are never high simultaneously.
  - busy = (state is WAIT_HIGH or WAIT_LOW), registered with the state.
- Latency:
  - Let E0 be the first rising edge that samples the new `in_raw` into stage 1.
  - out_level changes at edge E0 + SYNC_STAGES + STABLE_CYCLES - 1.
  - With defaults, that is E0+5.
- Bounce:
  - Any sync glitch back to out_level during WAIT restarts qualification from 0.
  - A pulse shorter than STABLE_CYCLES synchronized cycles never reaches out_level.
- enable deasserted:
  - Counter cleared and FSM returns to or stays in the IDLE state matching out_level.
  - out_level holds; no pulses.
  - On re-enable, qualification starts fresh on the next edge.
- Counter never wraps; it is bounded by STABLE_CYCLES-1.

Test Plan:
- Reset, then hold in_raw=0 for 10 cycles with enable=1 -> out_level=0, rise=fall=busy=0 throughout.
- Clean step: in_raw 0->1 sampled at E0 (clk period 10) -> busy high from E0+2, out_level=1 and rise=1 at E0+5, rise=0 at E0+6; later 1->0 gives fall at the matching edge.
- Bounce: in_raw toggles 1,0,1,0 every 10 ns for 40 ns, then holds 1 -> no pulse during bounce; single rise 5 edges after the final 0->1 sample.
- Short glitch: in_raw=1 for exactly 2 cycles with STABLE_CYCLES=4 -> out_level stays 0, busy pulses, no rise.
- enable=0 while in_raw goes 0->1 and holds 10 cycles -> out_level stays 0. Raise enable -> rise 4 edges later (sync already settled).
- Assert reset at E0+3 of a pending rise -> all outputs 0 immediately (asynchronously). After release with in_raw still 1 -> rise 5 edges after the first post-reset edge.
